monochrome_ctrl: RTL and testbench

- Control-side producer of the 2-bit monochrome_selection code consumed by the video path's colour/gray/orange/green converter.
- Holds the selected mode in a ZX-Uno register, readable and writable over the register bus.
- Optionally lets a keyboard hotkey cycle through the modes.
- A mode change never takes effect mid-frame: a newly requested mode is committed only at the next frame-start pulse, so the picture does not tear.

---
 rtl/monochrome_pkg.sv | 9 +
 rtl/monochrome_ctrl_hotkey_holdoff.sv | 33 +++
 rtl/monochrome_ctrl.sv | 80 ++++++++
 tb/tb_monochrome_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/monochrome_pkg.sv
// monochrome_pkg: shared mode codes and register bit positions for monochrome_ctrl.
package monochrome_pkg;
   localparam logic [1:0] MODE_COLOR  = 2'b00;
   localparam logic [1:0] MODE_GRAY   = 2'b01;
   localparam logic [1:0] MODE_ORANGE = 2'b10;
   localparam logic [1:0] MODE_GREEN  = 2'b11;
   localparam int LOCK_BIT    = 7;
   localparam int PENDING_BIT = 3;
endpackage

// File: rtl/monochrome_ctrl_hotkey_holdoff.sv
// hotkey_holdoff: hotkey rising-edge detect with a frame-counted holdoff after each accepted press.
//   clk, rst       clock, synchronous active-high reset
//   hotkey         keyboard level, already synchronous to clk
//   vsync_pulse    frame-start strobe, decrements the holdoff
//   enable         presses allowed (register not locked)
//   load_block     a register write this cycle drops the press
//   accept         one-cycle pulse for an accepted press
module hotkey_holdoff #(
   parameter int HOLDOFF_FRAMES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic hotkey,
   input  logic vsync_pulse,
   input  logic enable,
   input  logic load_block,
   output logic accept
);
   logic       prev;
   logic [7:0] holdoff;
   assign accept = hotkey && !prev && enable && holdoff == 8'd0 && !load_block;
   always_ff @(posedge clk) begin
      if (rst) begin
         prev    <= 1'b0;
         holdoff <= 8'd0;
      end else begin
         prev <= hotkey;
         // a fresh load outranks the per-frame decrement
         if (accept) holdoff <= 8'(HOLDOFF_FRAMES);
         else if (vsync_pulse && holdoff != 8'd0) holdoff <= holdoff - 8'd1;
      end
   end
endmodule

// File: rtl/monochrome_ctrl.sv
// monochrome_ctrl: ZX-Uno register holding the monochrome mode, committed only at frame start.
//   Optional hotkey cycling is built when MONOCHROME_HOTKEY_EN is defined.
//   clk, rst                  clock, synchronous active-high reset
//   zxuno_addr/regrd/regwr    register bus address and strobes, din write data
//   dout, oe                  read data and its drive enable
//   vsync_pulse               one-cycle frame-start strobe
//   hotkey                    keyboard level for mode cycling
//   monochrome_selection      committed mode, pending: request awaits next vsync
module monochrome_ctrl
   import monochrome_pkg::*;
#(
   parameter logic [7:0] REG_ADDR       = 8'h0F,
   parameter int         HOLDOFF_FRAMES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] zxuno_addr,
   input  logic       zxuno_regrd,
   input  logic       zxuno_regwr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       oe,
   input  logic       vsync_pulse,
   input  logic       hotkey,
   output logic [1:0] monochrome_selection,
   output logic       pending
);
   logic [1:0] target;
   logic       lock;
   logic       wr;
   logic       accept;
   assign wr = zxuno_regwr && zxuno_addr == REG_ADDR;
   assign oe = zxuno_regrd && zxuno_addr == REG_ADDR;
`ifdef MONOCHROME_HOTKEY_EN
   logic unused_din;
   assign unused_din = ^din[6:2];
   hotkey_holdoff #(.HOLDOFF_FRAMES(HOLDOFF_FRAMES)) u_hotkey (
      .clk(clk),
      .rst(rst),
      .hotkey(hotkey),
      .vsync_pulse(vsync_pulse),
      .enable(!lock),
      .load_block(wr),
      .accept(accept)
   );
`else
   // lock is storage only; hotkey and holdoff have no effect in this build
   localparam int unused_holdoff = HOLDOFF_FRAMES;
   logic unused_in;
   assign unused_in = ^{din[6:2], hotkey};
   assign accept = 1'b0;
`endif
   always_comb begin
      dout = 8'h00;
      dout[1:0] = target;
      dout[PENDING_BIT] = pending;
      dout[LOCK_BIT] = lock;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         monochrome_selection <= MODE_COLOR;
         target               <= MODE_COLOR;
         pending              <= 1'b0;
         lock                 <= 1'b0;
      end else begin
         // commit always uses the target held before any same-cycle request
         if (vsync_pulse && pending) monochrome_selection <= target;
         if (wr) begin
            target  <= din[1:0];
            lock    <= din[LOCK_BIT];
            pending <= 1'b1;
         end else if (accept) begin
            target  <= target + 2'd1;
            pending <= 1'b1;
         end else if (vsync_pulse) begin
            pending <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_monochrome_ctrl.sv
// tb_monochrome_ctrl: directed and randomized checks of monochrome_ctrl against a frame-level model.
module tb_monochrome_ctrl;
   localparam logic [7:0] RA = 8'h0F;
   localparam int HOLD = 2;
`ifdef MONOCHROME_HOTKEY_EN
   localparam bit HK = 1'b1;
`else
   localparam bit HK = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] zxuno_addr = 8'h00;
   logic       zxuno_regrd = 1'b0;
   logic       zxuno_regwr = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       oe;
   logic       vsync_pulse = 1'b0;
   logic       hotkey = 1'b0;
   logic [1:0] monochrome_selection;
   logic       pending;
   int tests = 0;
   int fails = 0;
   int m_sel = 0, m_target = 0, m_hold = 0;
   bit m_pending = 0, m_lock = 0, m_prev = 0;

   monochrome_ctrl #(.REG_ADDR(RA), .HOLDOFF_FRAMES(HOLD)) dut (
      .clk(clk),
      .rst(rst),
      .zxuno_addr(zxuno_addr),
      .zxuno_regrd(zxuno_regrd),
      .zxuno_regwr(zxuno_regwr),
      .din(din),
      .dout(dout),
      .oe(oe),
      .vsync_pulse(vsync_pulse),
      .hotkey(hotkey),
      .monochrome_selection(monochrome_selection),
      .pending(pending)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] m_read();
      return {m_lock, 3'b000, m_pending, 1'b0, 2'(m_target)};
   endfunction

   // one clock with the given inputs; the model applies the frame-level rules
   task automatic step(input bit w, input logic [7:0] a, input logic [7:0] d, input bit v, input bit h, input bit r = 0);
      bit wr, acc, edge_;
      zxuno_regwr = w; zxuno_addr = a; din = d; vsync_pulse = v; hotkey = h; rst = r;
      @(posedge clk);
      if (r) begin
         m_sel = 0; m_target = 0; m_pending = 0; m_lock = 0; m_hold = 0; m_prev = 0;
      end else begin
         edge_ = h && !m_prev;
         m_prev = h;
         wr = w && a == RA;
         acc = HK && edge_ && !m_lock && m_hold == 0 && !wr;
         if (v && m_pending) begin m_sel = m_target; m_pending = 0; end
         if (v && m_hold > 0) m_hold = m_hold - 1;
         if (wr) begin m_target = d[1:0]; m_lock = d[7]; m_pending = 1; end
         else if (acc) begin m_target = (m_target + 1) % 4; m_pending = 1; m_hold = HOLD; end
      end
      #1;
      zxuno_regwr = 0; vsync_pulse = 0; rst = 0;
   endtask

   task automatic read_at(input logic [7:0] a);
      zxuno_regrd = 1; zxuno_addr = a; #1;
   endtask

   task automatic test_reset();
      step(0, 8'h00, 8'h00, 0, 0, 1);
      read_at(RA);
      tests++; if (monochrome_selection !== 2'b00) begin fails++; $display("FAIL reset_sel got %b want 00", monochrome_selection); end
      tests++; if (pending !== 1'b0) begin fails++; $display("FAIL reset_pending got %b want 0", pending); end
      tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout got %h want 00", dout); end
      zxuno_regrd = 0; #1;
      tests++; if (oe !== 1'b0) begin fails++; $display("FAIL reset_oe got %b want 0", oe); end
   endtask

   task automatic test_write_commit();
      step(1, RA, 8'h02, 0, 0);
      tests++; if (pending !== 1'b1) begin fails++; $display("FAIL wc_pending got %b want 1", pending); end
      step(0, 8'h00, 8'h00, 0, 0);
      tests++; if (monochrome_selection !== 2'b00) begin fails++; $display("FAIL wc_hold got %b want 00", monochrome_selection); end
      step(0, 8'h00, 8'h00, 1, 0);
      tests++; if (monochrome_selection !== 2'b10) begin fails++; $display("FAIL wc_sel got %b want 10", monochrome_selection); end
      tests++; if (pending !== 1'b0) begin fails++; $display("FAIL wc_pend_clr got %b want 0", pending); end
      read_at(RA);
      tests++; if (dout !== 8'h02 || oe !== 1'b1) begin fails++; $display("FAIL wc_read got %h/%b want 02/1", dout, oe); end
      zxuno_regrd = 0;
   endtask

   task automatic test_latest_wins();
      step(1, RA, 8'h01, 0, 0);
      step(1, RA, 8'h03, 0, 0);
      read_at(RA);
      tests++; if (dout !== 8'h0B) begin fails++; $display("FAIL lw_read got %h want 0b", dout); end
      zxuno_regrd = 0;
      step(0, 8'h00, 8'h00, 1, 0);
      tests++; if (monochrome_selection !== 2'b11) begin fails++; $display("FAIL lw_sel got %b want 11", monochrome_selection); end
   endtask

   task automatic test_same_cycle();
      step(1, RA, 8'h02, 0, 0);
      step(1, RA, 8'h01, 1, 0);
      tests++; if (monochrome_selection !== 2'b10 || pending !== 1'b1) begin fails++; $display("FAIL sc_first got %b/%b want 10/1", monochrome_selection, pending); end
      step(0, 8'h00, 8'h00, 1, 0);
      tests++; if (monochrome_selection !== 2'b01 || pending !== 1'b0) begin fails++; $display("FAIL sc_second got %b/%b want 01/0", monochrome_selection, pending); end
   endtask

`ifdef MONOCHROME_HOTKEY_EN
   task automatic test_hotkey();
      step(1, RA, 8'h03, 0, 0);
      step(0, 8'h00, 8'h00, 1, 0);
      step(0, 8'h00, 8'h00, 0, 1);
      step(0, 8'h00, 8'h00, 0, 0);
      read_at(RA);
      tests++; if (dout !== 8'h08) begin fails++; $display("FAIL hk_first got %h want 08", dout); end
      zxuno_regrd = 0;
      step(0, 8'h00, 8'h00, 0, 1);
      step(0, 8'h00, 8'h00, 0, 0);
      read_at(RA);
      tests++; if (dout !== 8'h08) begin fails++; $display("FAIL hk_holdoff got %h want 08", dout); end
      zxuno_regrd = 0;
      step(0, 8'h00, 8'h00, 1, 0);
      step(0, 8'h00, 8'h00, 1, 0);
      step(0, 8'h00, 8'h00, 0, 1);
      step(0, 8'h00, 8'h00, 0, 0);
      read_at(RA);
      tests++; if (dout !== 8'h09) begin fails++; $display("FAIL hk_after got %h want 09", dout); end
      zxuno_regrd = 0;
      step(0, 8'h00, 8'h00, 1, 0);
   endtask
`endif

   task automatic test_lock();
      step(1, RA, 8'h80, 0, 0);
      step(0, 8'h00, 8'h00, 1, 0);
      step(0, 8'h00, 8'h00, 1, 0);
      step(0, 8'h00, 8'h00, 1, 0);
      step(0, 8'h00, 8'h00, 0, 1);
      step(0, 8'h00, 8'h00, 0, 0);
      read_at(RA);
      tests++; if (dout !== 8'h80) begin fails++; $display("FAIL lock_read got %h want 80", dout); end
      tests++; if (pending !== 1'b0) begin fails++; $display("FAIL lock_pending got %b want 0", pending); end
      zxuno_regrd = 0;
   endtask

   task automatic test_reset_mid();
      step(1, RA, 8'h03, 0, 0);
      step(0, 8'h00, 8'h00, 1, 0);
      step(1, RA, 8'h02, 0, 0);
      tests++; if (monochrome_selection !== 2'b11 || pending !== 1'b1) begin fails++; $display("FAIL rm_pre got %b/%b want 11/1", monochrome_selection, pending); end
      step(0, 8'h00, 8'h00, 0, 0, 1);
      read_at(RA);
      tests++; if (monochrome_selection !== 2'b00 || pending !== 1'b0) begin fails++; $display("FAIL rm_post got %b/%b want 00/0", monochrome_selection, pending); end
      tests++; if (dout !== 8'h00) begin fails++; $display("FAIL rm_read got %h want 00", dout); end
      read_at(8'h10);
      tests++; if (oe !== 1'b0) begin fails++; $display("FAIL rm_oe got %b want 0", oe); end
      zxuno_regrd = 0;
   endtask

   task automatic test_random();
      logic [7:0] a;
      for (int i = 0; i < 600; i++) begin
         a = ($urandom % 3 == 0) ? 8'($urandom) : RA;
         step($urandom % 5 == 0, a, 8'($urandom), $urandom % 6 == 0, $urandom % 3 == 0);
         zxuno_regrd = 1'($urandom); #1;
         tests++; if (monochrome_selection !== 2'(m_sel) || pending !== m_pending) begin fails++; $display("FAIL rnd_state[%0d] got %b/%b want %b/%b", i, monochrome_selection, pending, 2'(m_sel), m_pending); end
         tests++; if (dout !== m_read() || oe !== (zxuno_regrd && zxuno_addr == RA)) begin fails++; $display("FAIL rnd_read[%0d] got %h/%b want %h/%b", i, dout, oe, m_read(), zxuno_regrd && zxuno_addr == RA); end
         zxuno_regrd = 0;
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_write_commit();
      test_latest_wins();
      test_same_cycle();
`ifdef MONOCHROME_HOTKEY_EN
      test_hotkey();
`endif
      test_lock();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
